// File: rtl/wave_channel_ctrl.sv
// wave_channel_ctrl: shadow/live configuration registers and sample strobe
// for the summing oscillator bank, with atomic sample-aligned commits.
module wave_channel_ctrl #(
    parameter int CHANNELS   = 32,
    parameter int SAMPLE_DIV = 256,
    parameter int DIV_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [6:0]               wr_addr,
    input  logic [15:0]              wr_data,
    input  logic                     commit_req,
    output logic                     commit_done,
    input  logic                     run,
    output logic [CHANNELS*16-1:0]   amps,
    output logic [CHANNELS*16-1:0]   offsets,
    output logic [CHANNELS*16-1:0]   phasewords,
    output logic                     activein,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        COMMIT
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    state_t state_q, state_d;

    logic [DIV_W-1:0] div_q, div_d;
    logic             act_q;
    logic             done_q;
    logic             busy_q;
    logic             div_wrap;
    logic             copy;
    logic             wr_fire;

    logic [CHANNELS*16-1:0] amp_sh_q, off_sh_q, ph_sh_q;
    logic [CHANNELS*16-1:0] amp_q, off_q, ph_q;

    assign wr_ready = (state_q == IDLE);
    assign wr_fire  = wr_valid && wr_ready;
    assign div_wrap = run && (div_q == DIV_LAST);

    // Sample divider: free-runs while run is high, parks at zero otherwise.
    always_comb begin
        div_d = '0;
        if (run && !div_wrap) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Commit sequencer; a pending copy lands on the strobe edge when running.
    always_comb begin
        state_d = state_q;
        copy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (!run || div_wrap) begin
                    copy    = 1'b1;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, divider and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            act_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            act_q   <= div_wrap;
            done_q  <= (state_q == COMMIT);
            busy_q  <= (state_d == PENDING);
        end
    end

    // Host writes land in the shadow bank only; field 3 is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amp_sh_q <= '0;
            off_sh_q <= '0;
            ph_sh_q  <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_fire && (wr_addr[6:2] == 5'(c))) begin
                    case (wr_addr[1:0])
                        2'd0:    amp_sh_q[c*16 +: 16] <= wr_data;
                        2'd1:    off_sh_q[c*16 +: 16] <= wr_data;
                        2'd2:    ph_sh_q[c*16 +: 16]  <= wr_data;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Live bank: whole-bank copy so the oscillators never see a mix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            amp_q <= '0;
            off_q <= '0;
            ph_q  <= '0;
        end else if (copy) begin
            amp_q <= amp_sh_q;
            off_q <= off_sh_q;
            ph_q  <= ph_sh_q;
        end
    end

    assign amps        = amp_q;
    assign offsets     = off_q;
    assign phasewords  = ph_q;
    assign activein    = act_q;
    assign commit_done = done_q;
    assign busy        = busy_q;

endmodule
